// File: rtl/pattern_deadtime_if.sv
// rtl/pattern_deadtime_if.sv - pattern/status bundle between sequencer side and dead-time output stage
interface pattern_deadtime_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pat_in;
  logic             enable;
  logic             fault;
  logic             fault_clr;
  logic [WIDTH-1:0] pat_out;
  logic             busy;
  logic             fault_latched;
  logic             illegal;

  // Sequencer / controller side: drives the request and control lines
  modport master (
    output pat_in, enable, fault, fault_clr,
    input  pat_out, busy, fault_latched, illegal
  );

  // Dead-time stage side
  modport slave (
    input  pat_in, enable, fault, fault_clr,
    output pat_out, busy, fault_latched, illegal
  );
endinterface

// File: rtl/pattern_deadtime.sv
// rtl/pattern_deadtime.sv - break-before-make dead-time stage with enable gating and fault kill; optional DEADTIME_PAIR_LOCK_EN
module pattern_deadtime #(
  parameter int WIDTH       = 8,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input logic               clk,
  input logic               reset,
  pattern_deadtime_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DEAD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pat_q;
  logic             busy_q;
  logic             fault_q;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] on_bits;

`ifdef DEADTIME_PAIR_LOCK_EN
  logic viol;
  logic illegal_q;

  // Complementary pairs requested together are dropped before any other logic sees them
  always_comb begin
    pin  = bus.pat_in;
    viol = 1'b0;
    for (int k = 0; k + 1 < WIDTH; k += 2) begin
      if (bus.pat_in[k] && bus.pat_in[k+1]) begin
        pin[k]   = 1'b0;
        pin[k+1] = 1'b0;
        viol     = 1'b1;
      end
    end
  end

  // One-clock flag for every edge on which a pair violation is sampled
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= viol;
  end

  assign bus.illegal = illegal_q;
`else
  assign pin         = bus.pat_in;
  assign bus.illegal = 1'b0;
`endif

  // Bits that would newly turn on relative to what is currently driven
  assign on_bits = pin & ~pat_q;

  // Main control FSM: fault kill, enable gating, dead-time countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      cnt     <= '0;
      tgt     <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.fault) begin
      state   <= S_FAULT;
      cnt     <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b1;
    end else if (state == S_FAULT) begin
      // Latched fault only leaves through an explicit clear with the fault gone
      if (bus.fault_clr) begin
        state   <= S_RUN;
        fault_q <= 1'b0;
      end
    end else if (!bus.enable) begin
      state  <= S_RUN;
      cnt    <= '0;
      tgt    <= '0;
      pat_q  <= '0;
      busy_q <= 1'b0;
    end else if (state == S_RUN) begin
      if (on_bits == '0 || DEAD_CYCLES == 0) begin
        pat_q <= pin;
      end else begin
        pat_q  <= pat_q & pin;
        tgt    <= pin;
        cnt    <= DEAD_LOAD;
        state  <= S_DEAD;
        busy_q <= 1'b1;
      end
    end else begin
      if (pin != tgt) begin
        // Request moved mid-countdown: drop anything no longer wanted and start over
        pat_q <= pat_q & pin;
        tgt   <= pin;
        cnt   <= DEAD_LOAD;
      end else if (cnt == CNT_ONE) begin
        pat_q  <= tgt;
        state  <= S_RUN;
        busy_q <= 1'b0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign bus.pat_out       = pat_q;
  assign bus.busy          = busy_q;
  assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_pattern_deadtime.sv
// tb/tb_pattern_deadtime.sv - scoreboard bench for pattern_deadtime at DEAD_CYCLES=4 and DEAD_CYCLES=0
module tb_pattern_deadtime;
  localparam int W  = 8;
  localparam int DA = 4;
  localparam int DB = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_deadtime_if #(.WIDTH(W)) bus_a ();
  pattern_deadtime_if #(.WIDTH(W)) bus_b ();

  pattern_deadtime #(.WIDTH(W), .DEAD_CYCLES(DA), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  pattern_deadtime #(.WIDTH(W), .DEAD_CYCLES(DB), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       busy;
    logic       fl;
    logic       ill;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_no = 0;

  // Reference model: dead time tracked as an absolute edge deadline
  logic [7:0] m_out[2];
  logic [7:0] m_want[2];
  bit         m_wait[2];
  bit         m_flt[2];
  int         m_due[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int d, input logic [7:0] raw,
                            input bit en, input bit f, input bit clr, input bit rst,
                            output exp_t e);
    logic [7:0] p;
    bit bad;
    p   = raw;
    bad = 1'b0;
`ifdef DEADTIME_PAIR_LOCK_EN
    for (int k = 0; k < 8; k += 2) begin
      if (raw[k] && raw[k+1]) begin
        p[k]   = 1'b0;
        p[k+1] = 1'b0;
        bad    = 1'b1;
      end
    end
`endif
    if (rst) begin
      m_out[i] = '0; m_want[i] = '0; m_wait[i] = 0; m_flt[i] = 0; bad = 0;
    end else if (f) begin
      m_out[i] = '0; m_wait[i] = 0; m_flt[i] = 1;
    end else if (m_flt[i]) begin
      if (clr) m_flt[i] = 0;
    end else if (!en) begin
      m_out[i] = '0; m_want[i] = '0; m_wait[i] = 0;
    end else if (m_wait[i]) begin
      if (p != m_want[i]) begin
        m_out[i] = m_out[i] & p; m_want[i] = p; m_due[i] = edge_no + d;
      end else if (edge_no >= m_due[i]) begin
        m_out[i] = p; m_wait[i] = 0;
      end
    end else if ((p & ~m_out[i]) == '0 || d == 0) begin
      m_out[i] = p;
    end else begin
      m_out[i] = m_out[i] & p; m_want[i] = p; m_due[i] = edge_no + d; m_wait[i] = 1;
    end
    e.out  = m_out[i];
    e.busy = m_wait[i];
    e.fl   = m_flt[i];
    e.ill  = bad;
  endtask

  // Drive one edge worth of stimulus and queue the expected response for both instances
  task automatic step(input logic [7:0] p, input bit en, input bit f, input bit clr, input bit rst);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus_a.pat_in = p; bus_a.enable = en; bus_a.fault = f; bus_a.fault_clr = clr;
    bus_b.pat_in = p; bus_b.enable = en; bus_b.fault = f; bus_b.fault_clr = clr;
    edge_no++;
    model_step(0, DA, p, en, f, clr, rst, e);
    q_a.push_back(e);
    model_step(1, DB, p, en, f, clr, rst, e);
    q_b.push_back(e);
  endtask

  task automatic run(input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) step(p, 1, 0, 0, 0);
  endtask

  task automatic expect_a(input string name, input logic [7:0] v);
    @(posedge clk);
    #2;
    chk(name, bus_a.pat_out, v);
  endtask

  // Monitor: outputs are presented every clock; compare after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_pat_out", bus_a.pat_out, e.out);
        chk("a_busy", bus_a.busy, e.busy);
        chk("a_fault_latched", bus_a.fault_latched, e.fl);
        chk("a_illegal", bus_a.illegal, e.ill);
        chk("a_subset_of_in", bus_a.pat_out & ~bus_a.pat_in, 0);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_pat_out", bus_b.pat_out, e.out);
        chk("b_busy", bus_b.busy, e.busy);
        chk("b_fault_latched", bus_b.fault_latched, e.fl);
        chk("b_illegal", bus_b.illegal, e.ill);
      end
    end
  end

  initial begin
    logic [7:0] p;
    bit en, f, clr;
    reset = 1'b1;
    bus_a.pat_in = '0; bus_a.enable = 1'b0; bus_a.fault = 1'b0; bus_a.fault_clr = 1'b0;
    bus_b.pat_in = '0; bus_b.enable = 1'b0; bus_b.fault = 1'b0; bus_b.fault_clr = 1'b0;

    step(8'h00, 1, 0, 0, 1);
    step(8'h00, 1, 0, 0, 1);
    expect_a("reset_pat_out", 8'h00);

    // Dead time from all-zero
    run(8'b1001_0000, 4);
    chk("t1_held_off", bus_a.pat_out, 8'h00);
    step(8'b1001_0000, 1, 0, 0, 0);
    expect_a("t1_on", 8'b1001_0000);

    // Off bit drops immediately, new bit waits
    step(8'b0001_1000, 1, 0, 0, 0);
    expect_a("t2_off_first", 8'b0001_0000);
    run(8'b0001_1000, 3);
    step(8'b0001_1000, 1, 0, 0, 0);
    expect_a("t2_on", 8'b0001_1000);

    // Restart while counting down
    run(8'b0011_0000, 2);
    run(8'b0100_1000, 5);
    expect_a("t3_restart_done", 8'b0100_1000);

    // Fault kill and clear
    run(8'b0110_0000, 6);
    step(8'b0110_0000, 1, 1, 0, 0);
    expect_a("t4_fault_kill", 8'h00);
    step(8'b0110_0000, 1, 1, 1, 0);
    step(8'b0110_0000, 1, 0, 1, 0);
    run(8'b0110_0000, 5);
    expect_a("t4_recover", 8'b0110_0000);

    // Enable gating and re-enable dead time
    run(8'b0010_0100, 6);
    step(8'b0010_0100, 0, 0, 0, 0);
    expect_a("t5_disable", 8'h00);
    run(8'b0010_0100, 5);
    expect_a("t5_reenable", 8'b0010_0100);

    // Pair violation
    run(8'b1100_0100, 6);
`ifdef DEADTIME_PAIR_LOCK_EN
    expect_a("t6_masked", 8'b0000_0100);
`else
    expect_a("t6_unmasked", 8'b1100_0100);
`endif

    // Randomised traffic, mostly rate-limited pattern changes
    p = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) p = 8'($urandom);
      en  = ($urandom_range(0, 39) != 0);
      f   = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 3) == 0);
      step(p, en, f, clr, 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
